// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations and raises stall, flush and bubble.
// Define FWD_EN when a forwarding unit is present; without it the block interlocks on every RAW hazard.
module hazard_ctrl #(
  parameter int XADDR = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [XADDR-1:0] i_id_rd_addr,
  input  logic             i_id_rd_wr_en,
  input  logic             i_id_is_load,
  input  logic             i_redirect,
  input  logic             i_mem_busy,
  output logic             or_stall_if,
  output logic             or_stall_id,
  output logic             or_flush_id,
  output logic             or_bubble_ex,
  output logic [XADDR-1:0] or_fwd_rd_addr_mem,
  output logic [XADDR-1:0] or_fwd_rd_addr_wb,
  output logic             or_fwd_wr_en_mem,
  output logic             or_fwd_wr_en_wb,
  output logic [15:0]      or_hazard_cnt
);

  typedef struct packed {
    logic             valid;
    logic [XADDR-1:0] rd;
    logic             wr_en;
    logic             is_load;
  } slot_t;

  localparam slot_t       BUBBLE  = '0;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // x0 is hard-wired to zero, so a slot targeting it never produces a result worth waiting for.
  function automatic logic f_writer(input slot_t s);
    return s.valid & s.wr_en & (s.rd != '0);
  endfunction

  function automatic logic f_src_match(
    input slot_t            s,
    input logic             use1,
    input logic [XADDR-1:0] addr1,
    input logic             use2,
    input logic [XADDR-1:0] addr2
  );
    return f_writer(s) & ((use1 & (addr1 == s.rd)) | (use2 & (addr2 == s.rd)));
  endfunction

  slot_t       r_ex;
  slot_t       r_mem;
  slot_t       r_wb;
  slot_t       w_id_slot;
  logic [15:0] r_hazard_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_cnt_inc;
  logic        w_hazard;
  logic        w_ex_match;
  logic        w_stall;
  logic        w_flush;
  logic        w_bubble;
  logic        w_unused;

  assign w_ex_match = f_src_match(r_ex, i_id_rs1_used, i_id_rs1_addr,
                                  i_id_rs2_used, i_id_rs2_addr);

`ifdef FWD_EN
  // MEM and WB results are bypassed, so only a load still in EX forces a wait.
  assign w_hazard = i_id_valid & w_ex_match & r_ex.is_load;
`else
  logic w_mem_match;
  logic w_wb_match;

  assign w_mem_match = f_src_match(r_mem, i_id_rs1_used, i_id_rs1_addr,
                                   i_id_rs2_used, i_id_rs2_addr);
  assign w_wb_match  = f_src_match(r_wb, i_id_rs1_used, i_id_rs1_addr,
                                   i_id_rs2_used, i_id_rs2_addr);
  assign w_hazard    = i_id_valid & (w_ex_match | w_mem_match | w_wb_match);
`endif

  // Priority: reset, then memory busy, then redirect, then the RAW hazard.
  assign w_stall  = ~i_rst & (i_mem_busy | (w_hazard & ~i_redirect));
  assign w_flush  = i_rst | (i_redirect & ~i_mem_busy);
  assign w_bubble = i_rst | ((w_hazard | i_redirect) & ~i_mem_busy);

  assign or_stall_if  = w_stall;
  assign or_stall_id  = w_stall;
  assign or_flush_id  = w_flush;
  assign or_bubble_ex = w_bubble;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_id_slot = BUBBLE;
    if (i_id_valid && !w_bubble) begin
      w_id_slot.valid   = 1'b1;
      w_id_slot.rd      = i_id_rd_addr;
      w_id_slot.wr_en   = i_id_rd_wr_en;
      w_id_slot.is_load = i_id_is_load;
    end
  end

  // NOTE: non-blocking assignments let the three-stage shift read pre-edge values in any statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else if (!i_mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id_slot;
    end
  end

  assign w_cnt_inc = w_hazard & ~i_redirect & ~i_mem_busy;
  assign w_cnt_nxt = (w_cnt_inc && (r_hazard_cnt != CNT_MAX)) ? r_hazard_cnt + 16'd1 : r_hazard_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hazard_cnt <= '0;
    end else begin
      r_hazard_cnt <= w_cnt_nxt;
    end
  end

  assign or_hazard_cnt      = r_hazard_cnt;
  assign or_fwd_rd_addr_mem = r_mem.rd;
  assign or_fwd_rd_addr_wb  = r_wb.rd;
  assign or_fwd_wr_en_mem   = f_writer(r_mem);
  assign or_fwd_wr_en_wb    = f_writer(r_wb);

  // The WB load flag is tracked for completeness but nothing downstream consumes it.
  assign w_unused = r_wb.is_load;

endmodule
